// File: rtl/blur_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blur_seq_pkg
// Description : Shared types, defaults and helpers for the blur pipeline
//               sequencer (state encoding, default widths, bit search).
// Revision    : 1.0 - initial release
// ============================================================================
package blur_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        FINISH = 3'd4
    } seq_state_t;

    localparam int DEFAULT_ADDR_W = 19;
    localparam int DEFAULT_DATA_W = 36;
    localparam int MAX_STAGES     = 8;

    // Index of the lowest set bit of an 8-bit mask; 0 when the mask is empty.
    function automatic logic [2:0] lowest_set_bit(input logic [7:0] m);
        lowest_set_bit = 3'd0;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set_bit = 3'(i);
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/blur_pipeline_sequencer_mem_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_mux
// Description : Combinational NUM_STAGES:1 selector for the shared frame
//               memory port. Forces every output to zero when the select is
//               not valid.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_mux
    import blur_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W
) (
    input  logic [2:0]                   sel,
    input  logic                         sel_valid,
    input  logic [NUM_STAGES*ADDR_W-1:0] read_addr_in,
    input  logic [NUM_STAGES*ADDR_W-1:0] write_addr_in,
    input  logic [NUM_STAGES*DATA_W-1:0] write_data_in,
    input  logic [NUM_STAGES-1:0]        write_valid_in,
    output logic [ADDR_W-1:0]            read_addr,
    output logic [ADDR_W-1:0]            write_addr,
    output logic [DATA_W-1:0]            write_data,
    output logic                         write_valid
);

    // Pick the selected stage's fields; out-of-range selects read as zero.
    always_comb begin
        read_addr   = '0;
        write_addr  = '0;
        write_data  = '0;
        write_valid = 1'b0;
        if (sel_valid) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (sel == 3'(k)) begin
                    read_addr   = read_addr_in[k*ADDR_W +: ADDR_W];
                    write_addr  = write_addr_in[k*ADDR_W +: ADDR_W];
                    write_data  = write_data_in[k*DATA_W +: DATA_W];
                    write_valid = write_valid_in[k];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/blur_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : blur_pipeline_sequencer
// Description : Runs the enabled frame-processing stages one at a time on a
//               shared frame-memory port: one-cycle start pulse per stage,
//               waits for its done, steers the memory port to it.
//               Optional watchdog: define SEQ_WATCHDOG_EN to add the TIMEOUT
//               parameter and the sticky timeout output.
// Revision    : 1.0 - initial release
// ============================================================================
module blur_pipeline_sequencer
    import blur_seq_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W
`ifdef SEQ_WATCHDOG_EN
    ,
    parameter int TIMEOUT    = 2**22
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic                         abort,
    input  logic [NUM_STAGES-1:0]        stage_en,
    output logic [NUM_STAGES-1:0]        stage_start,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_read_addr,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_write_addr,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_write_data,
    input  logic [NUM_STAGES-1:0]        stage_write_valid,
    output logic [ADDR_W-1:0]            mem_read_addr,
    output logic [ADDR_W-1:0]            mem_write_addr,
    output logic [DATA_W-1:0]            mem_write_data,
    output logic                         mem_we,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
`ifdef SEQ_WATCHDOG_EN
    output logic                         timeout,
`endif
    output logic [2:0]                   cur_stage
);

    seq_state_t              state_q;
    seq_state_t              state_d;
    logic [7:0]              mask_q;
    logic [7:0]              mask_d;
    logic [7:0]              en_pad;
    logic [7:0]              done_pad;
    logic [7:0]              rem_mask;
    logic [2:0]              cur_q;
    logic [2:0]              cur_d;
    logic                    aborted_q;
    logic                    aborted_d;
    logic                    busy_q;
    logic                    done_q;
    logic [NUM_STAGES-1:0]   start_q;
    logic [NUM_STAGES-1:0]   start_d;
    logic                    kill;
    logic                    sel_valid;
    logic                    sel_write_valid;

    // Widen the per-stage vectors to the full 8-stage index space.
    always_comb begin
        en_pad                     = '0;
        done_pad                   = '0;
        en_pad[NUM_STAGES-1:0]     = stage_en;
        done_pad[NUM_STAGES-1:0]   = stage_done;
    end

    assign rem_mask = mask_q & ~(8'd1 << cur_q);

`ifdef SEQ_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt_q;
    logic          wd_hit;
    logic          timeout_q;

    // Cycle counter; zero outside RUN so it restarts on every RUN entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
        end else if (state_q != RUN) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    assign wd_hit = (state_q == RUN) && (wd_cnt_q == TW'(TIMEOUT - 1));

    // Sticky timeout flag, cleared by an accepted go.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if ((state_q == IDLE) && go) begin
            timeout_q <= 1'b0;
        end else if (wd_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
    assign kill    = abort | wd_hit;
`else
    assign kill    = abort;
`endif

    // Next-state, mask and stage-selection logic.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cur_d     = cur_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    mask_d    = en_pad;
                    cur_d     = lowest_set_bit(en_pad);
                    aborted_d = 1'b0;
                    state_d   = (|en_pad) ? START : FINISH;
                end
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                if (done_pad[cur_q]) begin
                    mask_d = rem_mask;
                    if (|rem_mask) begin
                        cur_d   = lowest_set_bit(rem_mask);
                        state_d = SETTLE;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            SETTLE: begin
                state_d = START;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort (or watchdog expiry) overrides everything outside IDLE.
        if ((state_q != IDLE) && kill) begin
            state_d   = IDLE;
            mask_d    = '0;
            aborted_d = 1'b1;
        end
    end

    // One-hot start pulse aligned with the START state.
    always_comb begin
        start_d = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            start_d[k] = (state_d == START) && (cur_d == 3'(k));
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            cur_q     <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            cur_q     <= cur_d;
            aborted_q <= aborted_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == FINISH);
            start_q   <= start_d;
        end
    end

    assign sel_valid = (state_q == START) || (state_q == RUN) || (state_q == SETTLE);

    mem_port_mux #(
        .NUM_STAGES (NUM_STAGES),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) u_mem_port_mux (
        .sel            (cur_q),
        .sel_valid      (sel_valid),
        .read_addr_in   (stage_read_addr),
        .write_addr_in  (stage_write_addr),
        .write_data_in  (stage_write_data),
        .write_valid_in (stage_write_valid),
        .read_addr      (mem_read_addr),
        .write_addr     (mem_write_addr),
        .write_data     (mem_write_data),
        .write_valid    (sel_write_valid)
    );

    // SETTLE keeps the port selected but blocks writes while addresses move.
    assign mem_we      = sel_write_valid && ((state_q == START) || (state_q == RUN));
    assign stage_start = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign cur_stage   = cur_q;

endmodule
`default_nettype wire

// File: tb/tb_blur_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_blur_pipeline_sequencer
// Description : Directed self-checking bench for blur_pipeline_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blur_pipeline_sequencer;

    localparam int NS = 3;
    localparam int AW = 19;
    localparam int DW = 36;

    logic              clk;
    logic              reset;
    logic              go;
    logic              abort;
    logic [NS-1:0]     stage_en;
    logic [NS-1:0]     stage_start;
    logic [NS-1:0]     stage_done;
    logic [NS*AW-1:0]  stage_read_addr;
    logic [NS*AW-1:0]  stage_write_addr;
    logic [NS*DW-1:0]  stage_write_data;
    logic [NS-1:0]     stage_write_valid;
    logic [AW-1:0]     mem_read_addr;
    logic [AW-1:0]     mem_write_addr;
    logic [DW-1:0]     mem_write_data;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [2:0]        cur_stage;

    int errors = 0;
    int checks = 0;

    blur_pipeline_sequencer #(
        .NUM_STAGES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .go                (go),
        .abort             (abort),
        .stage_en          (stage_en),
        .stage_start       (stage_start),
        .stage_done        (stage_done),
        .stage_read_addr   (stage_read_addr),
        .stage_write_addr  (stage_write_addr),
        .stage_write_data  (stage_write_data),
        .stage_write_valid (stage_write_valid),
        .mem_read_addr     (mem_read_addr),
        .mem_write_addr    (mem_write_addr),
        .mem_write_data    (mem_write_data),
        .mem_we            (mem_we),
        .busy              (busy),
        .done              (done),
        .aborted           (aborted),
        .cur_stage         (cur_stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] exp_rd(input int k);
        return 19'h01000 + 19'(k);
    endfunction
    function automatic logic [AW-1:0] exp_wa(input int k);
        return 19'h02000 + 19'(k);
    endfunction
    function automatic logic [DW-1:0] exp_wd(input int k);
        return 36'h0_0000_0100 + 36'(k);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_stage_fields;
        for (int k = 0; k < NS; k++) begin
            stage_read_addr[k*AW +: AW]  = exp_rd(k);
            stage_write_addr[k*AW +: AW] = exp_wa(k);
            stage_write_data[k*DW +: DW] = exp_wd(k);
        end
        stage_write_valid = 3'b111;
    endtask

    // Drive one pass and act as every enabled stage, replying after dly cycles.
    task automatic run_pass(input logic [2:0] en, input int dly, input string tag);
        int  w;
        bit  first;
        first    = 1'b1;
        go       = 1'b1;
        stage_en = en;
        tick;
        go = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (en[k]) begin
                w = 0;
                while (stage_start == '0 && w < 10) begin
                    tick;
                    w++;
                end
                checks++;
                if (stage_start !== 3'(1 << k) || cur_stage !== 3'(k)) begin
                    errors++;
                    $display("FAIL %s start k=%0d: got start=%b cur=%0d, expected start=%b cur=%0d",
                             tag, k, stage_start, cur_stage, 3'(1 << k), k);
                end
                checks++;
                if (w !== (first ? 0 : 1)) begin
                    errors++;
                    $display("FAIL %s start_gap k=%0d: got %0d extra cycles, expected %0d",
                             tag, k, w, first ? 0 : 1);
                end
                first = 1'b0;
                for (int c = 0; c < dly; c++) begin
                    tick;
                    checks++;
                    if (stage_start !== 3'b000 || busy !== 1'b1 || mem_read_addr !== exp_rd(k)) begin
                        errors++;
                        $display("FAIL %s run k=%0d c=%0d: got start=%b busy=%b rd=%h, expected start=000 busy=1 rd=%h",
                                 tag, k, c, stage_start, busy, mem_read_addr, exp_rd(k));
                    end
                end
                stage_done[k] = 1'b1;
                tick;
                stage_done = '0;
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || stage_start !== 3'b000) begin
            errors++;
            $display("FAIL %s finish: got done=%b busy=%b start=%b, expected done=1 busy=1 start=000",
                     tag, done, busy, stage_start);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got done=%b busy=%b, expected done=0 busy=0", tag, done, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #2;
        checks++;
        if (stage_start !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
            cur_stage !== 3'd0 || mem_we !== 1'b0 || mem_read_addr !== '0 ||
            mem_write_addr !== '0 || mem_write_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got start=%b busy=%b done=%b ab=%b cur=%0d we=%b rd=%h wa=%h wd=%h, expected all 0",
                     stage_start, busy, done, aborted, cur_stage, mem_we, mem_read_addr, mem_write_addr, mem_write_data);
        end
        tick;
        reset = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0 || stage_start !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got busy=%b start=%b, expected busy=0 start=000", busy, stage_start);
        end
    endtask

    task automatic test_all_stages;
        run_pass(3'b111, 20, "all");
    endtask

    task automatic test_skip_stage;
        run_pass(3'b101, 5, "skip");
    endtask

    task automatic test_empty_mask;
        go       = 1'b1;
        stage_en = 3'b000;
        tick;
        go = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || stage_start !== 3'b000) begin
            errors++;
            $display("FAIL empty_finish: got done=%b busy=%b start=%b, expected done=1 busy=1 start=000",
                     done, busy, stage_start);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || stage_start !== 3'b000) begin
            errors++;
            $display("FAIL empty_idle: got done=%b busy=%b start=%b, expected 0 0 000", done, busy, stage_start);
        end
    endtask

    task automatic test_mem_mux;
        stage_write_addr[0 +: AW] = 19'h12345;
        stage_write_data[0 +: DW] = 36'hABCDE;
        go       = 1'b1;
        stage_en = 3'b011;
        tick;
        go = 1'b0;
        checks++;
        if (mem_we !== 1'b1 || mem_write_addr !== 19'h12345 || mem_write_data !== 36'hABCDE) begin
            errors++;
            $display("FAIL mux_start: got we=%b wa=%h wd=%h, expected we=1 wa=12345 wd=abcde",
                     mem_we, mem_write_addr, mem_write_data);
        end
        tick;
        checks++;
        if (mem_we !== 1'b1 || mem_write_addr !== 19'h12345 || mem_write_data !== 36'hABCDE) begin
            errors++;
            $display("FAIL mux_run: got we=%b wa=%h wd=%h, expected we=1 wa=12345 wd=abcde",
                     mem_we, mem_write_addr, mem_write_data);
        end
        stage_write_addr[0 +: AW] = 19'h00777;
        stage_write_valid[0]      = 1'b0;
        #1;
        checks++;
        if (mem_write_addr !== 19'h00777 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL mux_comb: got wa=%h we=%b, expected wa=00777 we=0", mem_write_addr, mem_we);
        end
        stage_write_addr[0 +: AW] = 19'h12345;
        stage_write_valid[0]      = 1'b1;
        stage_done[0] = 1'b1;
        tick;
        stage_done = '0;
        checks++;
        if (mem_we !== 1'b0 || cur_stage !== 3'd1 || mem_write_addr !== exp_wa(1)) begin
            errors++;
            $display("FAIL mux_settle: got we=%b cur=%0d wa=%h, expected we=0 cur=1 wa=%h",
                     mem_we, cur_stage, mem_write_addr, exp_wa(1));
        end
        tick;
        checks++;
        if (mem_we !== 1'b1 || stage_start !== 3'b010 || mem_write_data !== exp_wd(1)) begin
            errors++;
            $display("FAIL mux_start1: got we=%b start=%b wd=%h, expected we=1 start=010 wd=%h",
                     mem_we, stage_start, mem_write_data, exp_wd(1));
        end
        tick;
        stage_done[1] = 1'b1;
        tick;
        stage_done = '0;
        checks++;
        if (done !== 1'b1 || mem_we !== 1'b0 || mem_write_addr !== '0 || mem_write_data !== '0) begin
            errors++;
            $display("FAIL mux_finish: got done=%b we=%b wa=%h wd=%h, expected done=1 we=0 wa=0 wd=0",
                     done, mem_we, mem_write_addr, mem_write_data);
        end
        tick;
        checks++;
        if (mem_we !== 1'b0 || mem_read_addr !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mux_idle: got we=%b rd=%h busy=%b, expected we=0 rd=0 busy=0",
                     mem_we, mem_read_addr, busy);
        end
        load_stage_fields;
    endtask

    task automatic test_abort;
        go       = 1'b1;
        stage_en = 3'b111;
        tick;
        go = 1'b0;
        tick;
        stage_done[0] = 1'b1;
        tick;
        stage_done = '0;
        tick;
        checks++;
        if (stage_start !== 3'b010) begin
            errors++;
            $display("FAIL abort_start1: got start=%b, expected 010", stage_start);
        end
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || aborted !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0 || stage_start !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b ab=%b done=%b we=%b start=%b, expected 0 1 0 0 000",
                     busy, aborted, done, mem_we, stage_start);
        end
        for (int c = 0; c < 6; c++) begin
            stage_done[1] = (c == 2);
            tick;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || stage_start !== 3'b000 || aborted !== 1'b1) begin
                errors++;
                $display("FAIL abort_late_done c=%0d: got done=%b busy=%b start=%b ab=%b, expected 0 0 000 1",
                         c, done, busy, stage_start, aborted);
            end
        end
        stage_done = '0;
        go       = 1'b1;
        abort    = 1'b1;
        stage_en = 3'b001;
        tick;
        go    = 1'b0;
        abort = 1'b0;
        checks++;
        if (aborted !== 1'b0 || stage_start !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got ab=%b start=%b busy=%b, expected 0 001 1",
                     aborted, stage_start, busy);
        end
        tick;
        stage_done[0] = 1'b1;
        tick;
        stage_done = '0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_done: got done=%b, expected 1", done);
        end
        tick;
    endtask

    task automatic test_reset_and_busy_go;
        go       = 1'b1;
        stage_en = 3'b111;
        tick;
        go = 1'b0;
        tick;
        stage_done[0] = 1'b1;
        tick;
        stage_done = '0;
        tick;
        tick;
        reset = 1'b0;
        #1;
        checks++;
        if (stage_start !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
            cur_stage !== 3'd0 || mem_we !== 1'b0 || mem_read_addr !== '0 || mem_write_addr !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got start=%b busy=%b done=%b ab=%b cur=%0d we=%b rd=%h wa=%h, expected all 0",
                     stage_start, busy, done, aborted, cur_stage, mem_we, mem_read_addr, mem_write_addr);
        end
        tick;
        reset = 1'b1;
        tick;
        stage_done[1] = 1'b1;
        tick;
        stage_done = '0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || stage_start !== 3'b000) begin
                errors++;
                $display("FAIL reset_late_done c=%0d: got busy=%b done=%b start=%b, expected 0 0 000",
                         c, busy, done, stage_start);
            end
            tick;
        end
        go       = 1'b1;
        stage_en = 3'b001;
        tick;
        stage_en = 3'b111;
        tick;
        go = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (stage_start !== 3'b000 || cur_stage !== 3'd0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_go c=%0d: got start=%b cur=%0d busy=%b, expected 000 0 1",
                         c, stage_start, cur_stage, busy);
            end
            if (c < 2) tick;
        end
        stage_done[0] = 1'b1;
        tick;
        stage_done = '0;
        checks++;
        if (done !== 1'b1 || stage_start !== 3'b000) begin
            errors++;
            $display("FAIL busy_go_done: got done=%b start=%b, expected 1 000", done, stage_start);
        end
        tick;
        checks++;
        if (busy !== 1'b0 || stage_start !== 3'b000) begin
            errors++;
            $display("FAIL busy_go_idle: got busy=%b start=%b, expected 0 000", busy, stage_start);
        end
    endtask

    initial begin
        go         = 1'b0;
        abort      = 1'b0;
        stage_en   = '0;
        stage_done = '0;
        load_stage_fields;
        test_reset;
        test_all_stages;
        test_skip_stage;
        test_empty_mask;
        test_mem_mux;
        test_abort;
        test_reset_and_busy_go;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
